// File: rtl/channel_serializer_pkg.sv
// ---------------------------------------------------------------------------
// channel_serializer_pkg
//
// Shared definitions for the channel serializer: the frame state enum, the
// channel count and channel-index width, and a saturating increment helper
// used by the optional stall counter.
//
// No ports (package).
// ---------------------------------------------------------------------------
package channel_serializer_pkg;

    // Frame-level states of the serializer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of colour channels held per pixel, and width of a channel index
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;

    // Index of the final channel in planar output order
    localparam logic [CH_W-1:0] LAST_CH = 2'd2;

    // Width of the optional stall counter
    localparam int STALL_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [STALL_W-1:0] sat_inc16(input logic [STALL_W-1:0] value);
        return (value == {STALL_W{1'b1}}) ? value : value + STALL_W'(1);
    endfunction

endpackage

// File: rtl/channel_serializer_mem.sv
// ---------------------------------------------------------------------------
// channel_serializer_mem
//
// Single-port sample buffer with a one-cycle synchronous read. A write takes
// the port for that cycle; otherwise a read request returns mem[addr] on
// rd_data one clock later. Contents are never cleared.
//
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write wr_data to mem[addr]
//   rd_en    in   read mem[addr] into rd_data (ignored while wr_en is high)
//   addr     in   ADDR_WIDTH  shared read/write address
//   wr_data  in   DATA_WIDTH  write data
//   rd_data  out  DATA_WIDTH  registered read data
// ---------------------------------------------------------------------------
module channel_serializer_mem
    import channel_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 16384,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE-1];

    // One access per cycle through the single port; writes win over reads.
    // The storage has no reset so it maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/channel_serializer.sv
// ---------------------------------------------------------------------------
// channel_serializer
//
// Collects Frame_Len pixel triples (one sample per channel) into three channel
// buffers, then streams them out channel-planar: all of channel 0, then all of
// channel 1, then all of channel 2, with a valid/ready handshake on each side.
//
// Optional feature macro: CHANNEL_SERIALIZER_STALL_CNT_EN adds the 16-bit
// CHANNEL_SERIALIZER_Stall_Count output (saturating count of DRAIN cycles in
// which output data waited on Out_Ready).
//
// Ports:
//   CHANNEL_SERIALIZER_Clk          in   clock, rising edge
//   CHANNEL_SERIALIZER_Reset        in   synchronous reset, active low
//   CHANNEL_SERIALIZER_Start        in   begin a frame (honoured in IDLE only)
//   CHANNEL_SERIALIZER_Frame_Len    in   ADDR_WIDTH+1  samples per channel
//   CHANNEL_SERIALIZER_In_Valid     in   input triple valid
//   CHANNEL_SERIALIZER_In_Data0/1/2 in   DATA_WIDTH  channel 0/1/2 sample
//   CHANNEL_SERIALIZER_In_Ready     out  triple accepted with In_Valid
//   CHANNEL_SERIALIZER_Out_Ready    in   downstream ready
//   CHANNEL_SERIALIZER_Out_Valid    out  Out_Data valid
//   CHANNEL_SERIALIZER_Out_Data     out  DATA_WIDTH  serialized sample
//   CHANNEL_SERIALIZER_Out_Channel  out  2  channel of Out_Data
//   CHANNEL_SERIALIZER_Out_Ch_Last  out  last sample of its channel
//   CHANNEL_SERIALIZER_Busy         out  high outside IDLE
//   CHANNEL_SERIALIZER_Stall_Count  out  16 (only with the macro above)
//   CHANNEL_SERIALIZER_Done         out  one-cycle frame-complete pulse
// ---------------------------------------------------------------------------
module channel_serializer
    import channel_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_SIZE   = 16384,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  CHANNEL_SERIALIZER_Clk,
    input  logic                  CHANNEL_SERIALIZER_Reset,
    input  logic                  CHANNEL_SERIALIZER_Start,
    input  logic [ADDR_WIDTH:0]   CHANNEL_SERIALIZER_Frame_Len,
    input  logic                  CHANNEL_SERIALIZER_In_Valid,
    input  logic [DATA_WIDTH-1:0] CHANNEL_SERIALIZER_In_Data0,
    input  logic [DATA_WIDTH-1:0] CHANNEL_SERIALIZER_In_Data1,
    input  logic [DATA_WIDTH-1:0] CHANNEL_SERIALIZER_In_Data2,
    output logic                  CHANNEL_SERIALIZER_In_Ready,
    input  logic                  CHANNEL_SERIALIZER_Out_Ready,
    output logic                  CHANNEL_SERIALIZER_Out_Valid,
    output logic [DATA_WIDTH-1:0] CHANNEL_SERIALIZER_Out_Data,
    output logic [CH_W-1:0]       CHANNEL_SERIALIZER_Out_Channel,
    output logic                  CHANNEL_SERIALIZER_Out_Ch_Last,
    output logic                  CHANNEL_SERIALIZER_Busy,
`ifdef CHANNEL_SERIALIZER_STALL_CNT_EN
    output logic [STALL_W-1:0]    CHANNEL_SERIALIZER_Stall_Count,
`endif
    output logic                  CHANNEL_SERIALIZER_Done
);

    localparam int              LEN_W   = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MEM_SIZE);

    // Frame control
    state_t                  state;
    logic [LEN_W-1:0]        len_m1;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [CH_W-1:0]         rd_ch;
    logic                    rd_active;
    logic                    in_ready;
    logic                    busy;
    logic                    done;

    // Read pipeline: pending buffer read, output register, skid register
    logic                    pend;
    logic [CH_W-1:0]         pend_ch;
    logic                    pend_last;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_last;
    logic                    skid_valid;
    logic [DATA_WIDTH-1:0]   skid_data;
    logic [CH_W-1:0]         skid_ch;
    logic                    skid_last;

    // Combinational control
    logic                    start_ok;
    logic [LEN_W-1:0]        start_len;
    logic                    accept;
    logic                    fire;
    logic                    issue;
    logic                    wr_last;
    logic                    rd_last;
    logic [1:0]              held;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   wr_word [NUM_CH];
    logic [DATA_WIDTH-1:0]   rd_bank [NUM_CH];
    logic [DATA_WIDTH-1:0]   rd_word;

    // Handshake decode and read-issue decision.
    // "held" counts samples that already own a slot in the two-entry
    // output stage (output reg, skid reg, or a read in flight) once this
    // cycle's transfer has left. A new read is issued only if its data is
    // guaranteed a slot next cycle, so nothing is ever dropped, while a
    // steady Out_Ready still lets a read go out every cycle.
    always_comb begin
        start_ok  = CHANNEL_SERIALIZER_Start && (state == ST_IDLE);
        start_len = (CHANNEL_SERIALIZER_Frame_Len > MAX_LEN) ? MAX_LEN
                                                              : CHANNEL_SERIALIZER_Frame_Len;
        accept    = in_ready && CHANNEL_SERIALIZER_In_Valid;
        fire      = out_valid && CHANNEL_SERIALIZER_Out_Ready;
        wr_last   = ({1'b0, wr_ptr} == len_m1);
        rd_last   = ({1'b0, rd_ptr} == len_m1);
        held      = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(fire);
        issue     = (state == ST_DRAIN) && rd_active && (held < 2'd2);
        mem_addr  = (state == ST_FILL) ? wr_ptr : rd_ptr;
    end

    // Select the returning read by the channel tag that travelled with it
    always_comb begin
        rd_word = rd_bank[0];
        case (pend_ch)
            2'd1:    rd_word = rd_bank[1];
            2'd2:    rd_word = rd_bank[2];
            default: rd_word = rd_bank[0];
        endcase
    end

    assign wr_word[0] = CHANNEL_SERIALIZER_In_Data0;
    assign wr_word[1] = CHANNEL_SERIALIZER_In_Data1;
    assign wr_word[2] = CHANNEL_SERIALIZER_In_Data2;

    // One buffer per channel; all share the address, only the channel
    // currently being drained is read.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_buf
        channel_serializer_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .MEM_SIZE   (MEM_SIZE),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_mem (
            .clk     (CHANNEL_SERIALIZER_Clk),
            .wr_en   (accept),
            .rd_en   (issue && (rd_ch == CH_W'(k))),
            .addr    (mem_addr),
            .wr_data (wr_word[k]),
            .rd_data (rd_bank[k])
        );
    end

    // Frame FSM with its pointers and registered status outputs.
    // rd_ptr/rd_ch walk the buffers at read-issue time, which runs up to two
    // samples ahead of the output port; the frame ends on the transfer of the
    // last sample of the last channel, not on the last read.
    always_ff @(posedge CHANNEL_SERIALIZER_Clk) begin
        if (!CHANNEL_SERIALIZER_Reset) begin
            state     <= ST_IDLE;
            len_m1    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_ch     <= '0;
            rd_active <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        rd_ch  <= '0;
                        busy   <= 1'b1;
                        if (start_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            len_m1   <= start_len - LEN_W'(1);
                            state    <= ST_FILL;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        if (wr_last) begin
                            state     <= ST_DRAIN;
                            in_ready  <= 1'b0;
                            rd_active <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (issue) begin
                        if (rd_last) begin
                            rd_ptr <= '0;
                            if (rd_ch == LAST_CH) begin
                                rd_active <= 1'b0;
                            end else begin
                                rd_ch <= rd_ch + CH_W'(1);
                            end
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                        end
                    end
                    if (fire && out_last && (out_ch == LAST_CH)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stage: output register backed by a one-entry skid register.
    // When the output register is free (empty or transferring) it takes the
    // skid entry first, otherwise the returning read; a read that returns
    // during a stall parks in the skid register, so the visible output word
    // never changes while it is waiting.
    always_ff @(posedge CHANNEL_SERIALIZER_Clk) begin
        if (!CHANNEL_SERIALIZER_Reset) begin
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ch    <= '0;
            skid_last  <= 1'b0;
        end else begin
            pend      <= issue;
            pend_ch   <= rd_ch;
            pend_last <= rd_last;
            if (!out_valid || fire) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                    out_ch    <= skid_ch;
                    out_last  <= skid_last;
                    if (pend) begin
                        skid_data <= rd_word;
                        skid_ch   <= pend_ch;
                        skid_last <= pend_last;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (pend) begin
                    out_valid <= 1'b1;
                    out_data  <= rd_word;
                    out_ch    <= pend_ch;
                    out_last  <= pend_last;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_word;
                skid_ch    <= pend_ch;
                skid_last  <= pend_last;
            end
        end
    end

`ifdef CHANNEL_SERIALIZER_STALL_CNT_EN
    logic [STALL_W-1:0] stall_count;

    // Count cycles where a valid output word is held back by the consumer;
    // a new frame starts the count from zero.
    always_ff @(posedge CHANNEL_SERIALIZER_Clk) begin
        if (!CHANNEL_SERIALIZER_Reset) begin
            stall_count <= '0;
        end else if (start_ok) begin
            stall_count <= '0;
        end else if ((state == ST_DRAIN) && out_valid && !CHANNEL_SERIALIZER_Out_Ready) begin
            stall_count <= sat_inc16(stall_count);
        end
    end

    assign CHANNEL_SERIALIZER_Stall_Count = stall_count;
`endif

    assign CHANNEL_SERIALIZER_In_Ready     = in_ready;
    assign CHANNEL_SERIALIZER_Out_Valid    = out_valid;
    assign CHANNEL_SERIALIZER_Out_Data     = out_data;
    assign CHANNEL_SERIALIZER_Out_Channel  = out_ch;
    assign CHANNEL_SERIALIZER_Out_Ch_Last  = out_last;
    assign CHANNEL_SERIALIZER_Busy         = busy;
    assign CHANNEL_SERIALIZER_Done         = done;

endmodule

// File: doc/channel_serializer.md
CHANNEL_SERIALIZER -- requirements
Module: channel_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, word width of each channel sample.
REQ-002 SHALL have parameter MEM_SIZE, default 16384, depth of each of the three channel buffers.
REQ-003 SHALL have parameter ADDR_WIDTH, default 14, buffer address width, with 2**ADDR_WIDTH >= MEM_SIZE.
REQ-004 CHANNEL_SERIALIZER_Clk  in  1  single clock; all logic on its rising edge.
REQ-005 CHANNEL_SERIALIZER_Reset  in  1  synchronous, active-low reset.
REQ-006 CHANNEL_SERIALIZER_Start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
REQ-007 CHANNEL_SERIALIZER_Frame_Len  in  ADDR_WIDTH+1  samples per channel; sampled on an honoured Start.
REQ-008 CHANNEL_SERIALIZER_In_Valid  in  1  input triple valid.
REQ-009 CHANNEL_SERIALIZER_In_Data0 / In_Data1 / In_Data2  in  DATA_WIDTH each  channel 0/1/2 samples of one pixel.
REQ-010 CHANNEL_SERIALIZER_In_Ready  out  1  triple accepted when In_Valid and In_Ready are both high.
REQ-011 CHANNEL_SERIALIZER_Out_Ready  in  1  downstream ready.
REQ-012 CHANNEL_SERIALIZER_Out_Valid  out  1  Out_Data valid.
REQ-013 CHANNEL_SERIALIZER_Out_Data  out  DATA_WIDTH  serialized sample.
REQ-014 CHANNEL_SERIALIZER_Out_Channel  out  2  channel index of Out_Data (0..2).
REQ-015 CHANNEL_SERIALIZER_Out_Ch_Last  out  1  Out_Data is the last sample of its channel.
REQ-016 CHANNEL_SERIALIZER_Busy  out  1  high in every state other than IDLE.
REQ-017 CHANNEL_SERIALIZER_Done  out  1  one-cycle pulse when a frame completes.

Function
REQ-018 SHALL implement states IDLE, FILL, DRAIN and DONE: IDLE->FILL on Start, FILL->DRAIN after Frame_Len accepted triples, DRAIN->DONE after 3*Frame_Len output transfers, and DONE->IDLE unconditionally after one cycle.
REQ-019 In FILL, In_Ready SHALL be 1, and each accepted triple SHALL write In_DataK to buffer K at wr_ptr and then increment wr_ptr; wr_ptr SHALL clear on Start.
REQ-020 In any state other than FILL, In_Ready SHALL be 0 and In_Data SHALL be ignored.
REQ-021 In DRAIN, output SHALL be channel-planar: all of channel 0 in address order, then all of channel 1, then all of channel 2.
REQ-022 An output transfer SHALL occur when Out_Valid and Out_Ready are both high.
REQ-023 While Out_Valid=1 and Out_Ready=0, Out_Data, Out_Channel and Out_Ch_Last SHALL hold stable.
REQ-024 Buffers SHALL have a one-cycle synchronous read; the first Out_Valid SHALL occur 2 cycles after DRAIN entry.
REQ-025 With Out_Ready held at 1, throughput SHALL be 1 word/cycle with no bubbles, including across channel boundaries.
REQ-026 Under any Out_Ready pattern, no sample SHALL be lost or duplicated (skid/prefetch register permitted).
REQ-027 Out_Ch_Last SHALL be asserted on sample Frame_Len-1 of each channel.
REQ-028 The rd_ptr SHALL wrap to 0 and the channel counter SHALL increment on that transfer.
REQ-029 Done SHALL be high exactly in the DONE state.
REQ-030 Frame_Len=0 SHALL cause IDLE->DONE directly, with no In_Ready and no output.
REQ-031 Frame_Len>MEM_SIZE SHALL be clamped to MEM_SIZE.
REQ-032 Start outside IDLE SHALL be ignored.
REQ-033 When Start and the last FILL acceptance coincide, the acceptance SHALL take priority (Start ignored).

Reset
REQ-034 While Reset=0 at a clock edge: state<=IDLE; pointers, channel counter and skid register cleared.
REQ-035 Under reset, all outputs SHALL be 0.
REQ-036 Reset mid-FILL/DRAIN SHALL abort the frame with no Done pulse.
REQ-037 Buffer contents SHALL NOT be cleared by reset.

Configuration
REQ-038 With CHANNEL_SERIALIZER_STALL_CNT_EN defined, SHALL add output CHANNEL_SERIALIZER_Stall_Count (16 bits), counting DRAIN cycles with Out_Valid=1 and Out_Ready=0, saturating at 16'hFFFF.
REQ-039 Stall_Count SHALL clear on an honoured Start and on reset.
REQ-040 Without CHANNEL_SERIALIZER_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Structure
REQ-041 A shared package SHALL hold the state enum (IDLE/FILL/DRAIN/DONE), NUM_CH=3 and the channel-index width 2.
REQ-042 The block SHALL contain one sub-module, the existing CHANNEL_MEM-style single-port buffer instantiated three times; FSM, counters and skid register SHALL be in channel_serializer.

Verification
REQ-043 Frame_Len=4, triples (k,16+k,32+k) for k=0..3, Out_Ready=1 -> Out_Data 0,1,2,3,16..19,32..35 on 12 consecutive cycles; Out_Ch_Last on 3,19,35; then a single Done.
REQ-044 Same frame, Out_Ready toggling 1,0,1,0... -> identical sequence; data stable during every stall; Stall_Count=11 when the macro is defined.
REQ-045 Frame_Len=0 with Start -> Done exactly 2 cycles later; In_Ready and Out_Valid never high.
REQ-046 Frame_Len=3, In_Valid gapped, Start pulsed mid-FILL -> Start ignored; output equals the 9 accepted samples in planar order.
REQ-047 Reset=0 asserted after 5 output transfers -> next cycle all outputs 0 and state IDLE; a new Start runs a full frame correctly.
REQ-048 Frame_Len=MEM_SIZE+5 -> exactly MEM_SIZE triples accepted and 3*MEM_SIZE words output.
